// File: rtl/image_stream_reader_pkg.sv
// Shared types and constants for the output-image stream reader.
// Holds the FSM state type, address field widths and the address-forming helper.
package image_stream_pkg;

    localparam int IMG_ADDR_W = 16;
    localparam int SEG_W      = 3;
    localparam logic [SEG_W-1:0] SEG_OUT_BASE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
`ifdef IMAGE_STREAM_CHECKSUM_EN
        ST_SUM,
`endif
        ST_FIN
    } state_e;

    function automatic logic [31:0] form_addr(input logic [SEG_W-1:0] seg,
                                              input logic [IMG_ADDR_W-1:0] pix);
        return {{(32-SEG_W-IMG_ADDR_W){1'b0}}, seg, pix};
    endfunction

endpackage

// File: rtl/image_stream_reader_if.sv
// Memory read path plus byte stream, bundled; master = reader, slave = RAM/transmitter side.
// Stream uses valid/ready: a byte moves when tx_valid_o & tx_ready_i at a rising edge.
interface image_stream_if;
    logic [31:0] mem_addr_o;
    logic        mem_rden_o;
    logic [7:0]  mem_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    modport master (
        output mem_addr_o, mem_rden_o, tx_data_o, tx_valid_o,
        input  mem_data_i, tx_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_rden_o, tx_data_o, tx_valid_o,
        output mem_data_i, tx_ready_i
    );
endinterface

// File: rtl/image_stream_reader_addr_gen.sv
// Pixel/bank counters, last-byte flag and registered memory address; updates one cycle after clear/advance.
// No backpressure of its own: the FSM only pulses advance_i on a stream handshake.
module image_addr_gen
    import image_stream_pkg::*;
#(
    parameter int                PIXELS    = 65536,
    parameter int                BANKS     = 3,
    parameter logic [SEG_W-1:0]  BANK_BASE = SEG_OUT_BASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear_i,
    input  logic        advance_i,
    output logic [31:0] addr_o,
    output logic        last_o
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [16:0]       pix_q,  pix_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [31:0]       addr_q, addr_d;

    assign last_o = (pix_q == 17'(PIXELS - 1)) && (bank_q == BANK_W'(BANKS - 1));
    assign addr_o = addr_q;

    always_comb begin
        pix_d  = pix_q;
        bank_d = bank_q;
        addr_d = addr_q;
        if (clear_i) begin
            pix_d  = '0;
            bank_d = '0;
        end else if (advance_i) begin
            if (bank_q == BANK_W'(BANKS - 1)) begin
                bank_d = '0;
                pix_d  = pix_q + 17'd1;
            end else begin
                bank_d = bank_q + BANK_W'(1);
            end
        end
        // After the final byte the address is left alone rather than pointing past the image.
        if (clear_i || (advance_i && !last_o)) begin
            addr_d = form_addr(BANK_BASE + SEG_W'(bank_d), pix_d[IMG_ADDR_W-1:0]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pix_q  <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            pix_q  <= pix_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// Reads the output image banks pixel-interleaved and streams bytes; first byte valid RD_LATENCY+1 edges after start.
// Stream byte held until tx_ready_i; optional trailing checksum byte under IMAGE_STREAM_CHECKSUM_EN.
module image_stream_reader
    import image_stream_pkg::*;
#(
    parameter int                PIXELS     = 65536,
    parameter int                BANKS      = 3,
    parameter logic [SEG_W-1:0]  BANK_BASE  = SEG_OUT_BASE,
    parameter int                RD_LATENCY = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    image_stream_if.master bus
);

    state_e      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        clear, advance, last, hs;
    logic [31:0] addr;
`ifdef IMAGE_STREAM_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    image_addr_gen #(
        .PIXELS    (PIXELS),
        .BANKS     (BANKS),
        .BANK_BASE (BANK_BASE)
    ) u_addr_gen (
        .CLK       (CLK),
        .RST       (RST),
        .clear_i   (clear),
        .advance_i (advance),
        .addr_o    (addr),
        .last_o    (last)
    );

    assign hs = tx_valid_q && bus.tx_ready_i;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        clear      = 1'b0;
        advance    = 1'b0;
`ifdef IMAGE_STREAM_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clear   = 1'b1;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_d  = 2'(RD_LATENCY - 1);
                state_d = (RD_LATENCY == 1) ? ST_SEND : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == 2'd0) begin
                    tx_data_d  = bus.mem_data_i;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_SEND: begin
                // Single-cycle latency skips WAIT, so the capture happens on SEND's first edge.
                if (!tx_valid_q) begin
                    tx_data_d  = bus.mem_data_i;
                    tx_valid_d = 1'b1;
                end else if (hs) begin
                    tx_valid_d = 1'b0;
                    advance    = 1'b1;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                    sum_d      = sum_q + tx_data_q;
                    state_d    = last ? ST_SUM : ST_REQ;
`else
                    state_d    = last ? ST_FIN : ST_REQ;
`endif
                end
            end
`ifdef IMAGE_STREAM_CHECKSUM_EN
            ST_SUM: begin
                if (!tx_valid_q) begin
                    tx_data_d  = sum_q;
                    tx_valid_d = 1'b1;
                end else if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats a same-cycle handshake: counters stay where they are.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef IMAGE_STREAM_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef IMAGE_STREAM_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_FIN);
    assign bus.mem_rden_o = (state_q == ST_REQ);
    assign bus.mem_addr_o = addr;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;

endmodule
